bin_frame_averager: RTL and testbench

Downstream stage of the N-bin collector: takes each collected vector of BINS spectral bins, accumulates 2^N_AVGS consecutive vectors per bin, and emits the per-bin average. It also pulses a one-cycle valid when each average is ready. It sits between the bin collector and the readout/packetizer logic.

---
 rtl/bin_frame_averager.sv | 114 +++++++++++
 tb/tb_bin_frame_averager.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_frame_averager.sv
// Averages 2^N_AVGS consecutive BINS-wide frames per bin.
// ROUND_EN selects round-half-up on the final divide.
module bin_frame_averager #(
  parameter int N         = 16,
  parameter int N_AVGS    = 7,
  parameter int SUM_WIDTH = 128,
  parameter int BINS      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [BINS-1:0][N-1:0] in_data,
  input  logic                 clear,
  output logic                 out_valid,
  output logic [BINS-1:0][N-1:0] out_data,
  output logic                 busy
);

  localparam int CW = (N_AVGS > 0) ? N_AVGS : 1;

`ifdef ROUND_EN
  localparam logic [SUM_WIDTH-1:0] HALF =
    (SUM_WIDTH'(1) << N_AVGS) >> 1;
`else
  localparam logic [SUM_WIDTH-1:0] HALF = '0;
`endif

  if (SUM_WIDTH < N + N_AVGS) begin : g_width_chk
    $error("SUM_WIDTH too small for N+N_AVGS");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DUMP
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        frame_cnt;
  logic [SUM_WIDTH-1:0] acc [BINS];
  logic [SUM_WIDTH-1:0] sum [BINS];
  logic                 last;

  // the incoming frame completes the average
  assign last = (N_AVGS == 0) || (&frame_cnt);

  // per-bin running sum including the frame on in_data
  always_comb begin
    for (int b = 0; b < BINS; b++) begin
      sum[b] = acc[b] + SUM_WIDTH'(in_data[b]);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and status outputs
  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (!clear && in_valid)
          state_nx = last ? DUMP : ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (clear)
          state_nx = IDLE;
        else if (in_valid)
          state_nx = last ? DUMP : ACCUM;
      end
      DUMP: begin
        out_valid = 1'b1;
        if (clear)
          state_nx = IDLE;
        else if (in_valid)
          state_nx = last ? DUMP : ACCUM;
        else
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // accumulators, frame counter and published average
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      out_data  <= '0;
      for (int b = 0; b < BINS; b++) acc[b] <= '0;
    end else if (clear) begin
      frame_cnt <= '0;
      for (int b = 0; b < BINS; b++) acc[b] <= '0;
    end else if (in_valid) begin
      if (last) begin
        frame_cnt <= '0;
        for (int b = 0; b < BINS; b++) begin
          acc[b]      <= '0;
          out_data[b] <= N'((sum[b] + HALF) >> N_AVGS);
        end
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
        for (int b = 0; b < BINS; b++) acc[b] <= sum[b];
      end
    end
  end

endmodule

// File: tb/tb_bin_frame_averager.sv
// Bench for bin_frame_averager: frame-count model plus
// hand-computed literal expectations.
module tb_bin_frame_averager;

  localparam int N      = 16;
  localparam int NA     = 2;
  localparam int SW     = 32;
  localparam int BINS   = 4;
  localparam int FRAMES = 1 << NA;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   clear;
  logic [BINS-1:0][N-1:0] in_data;
  logic                   out_valid;
  logic [BINS-1:0][N-1:0] out_data;
  logic                   busy;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  // model state
  int          m_nfr;
  longint      m_sum [BINS];
  logic        e_valid;
  logic        e_busy;
  logic [N-1:0] e_data [BINS];

  bin_frame_averager #(
    .N(N), .N_AVGS(NA), .SUM_WIDTH(SW), .BINS(BINS)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_data(in_data), .clear(clear),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] avg(longint s);
`ifdef ROUND_EN
    return N'((s + FRAMES / 2) / FRAMES);
`else
    return N'(s / FRAMES);
`endif
  endfunction

  // model: count frames of the current average, publish on the last
  always @(posedge clk) begin
    if (reset) begin
      m_nfr   = 0;
      e_valid = 1'b0;
      for (int b = 0; b < BINS; b++) begin
        m_sum[b]  = 0;
        e_data[b] = '0;
      end
    end else begin
      e_valid = 1'b0;
      if (clear) begin
        m_nfr = 0;
        for (int b = 0; b < BINS; b++) m_sum[b] = 0;
      end else if (in_valid) begin
        m_nfr++;
        for (int b = 0; b < BINS; b++)
          m_sum[b] += longint'(in_data[b]);
        if (m_nfr == FRAMES) begin
          e_valid = 1'b1;
          for (int b = 0; b < BINS; b++) begin
            e_data[b] = avg(m_sum[b]);
            m_sum[b]  = 0;
          end
          m_nfr = 0;
        end
      end
    end
    e_busy = (m_nfr > 0);
  end

  task automatic chk(string nm, longint got, longint exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("out_valid", out_valid, e_valid);
      chk("busy", busy, e_busy);
      for (int b = 0; b < BINS; b++)
        chk($sformatf("out_data[%0d]", b), out_data[b], e_data[b]);
    end
  end

  task automatic step(bit v, int d0, int d1, int d2, int d3,
                      bit clr = 1'b0, bit rst = 1'b0);
    in_valid   = v;
    in_data[0] = N'(d0);
    in_data[1] = N'(d1);
    in_data[2] = N'(d2);
    in_data[3] = N'(d3);
    clear      = clr;
    reset      = rst;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 0);
  endtask

  int pulses;
  int p_idx [$];
  int p_val [$];

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    in_data  = '0;
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst out_data", out_data, 0);
    reset = 1'b0;
    idle();

    // constant frames
    step(1, 100, 200, 300, 400);
    chk("const busy1", busy, 1);
    step(1, 100, 200, 300, 400);
    step(1, 100, 200, 300, 400);
    chk("const busy3", busy, 1);
    chk("const novalid", out_valid, 0);
    step(1, 100, 200, 300, 400);
    chk("const valid", out_valid, 1);
    chk("const busy_dump", busy, 0);
    chk("const d0", out_data[0], 100);
    chk("const d3", out_data[3], 400);
    idle();
    chk("const pulse1", out_valid, 0);
    chk("const hold", out_data[2], 300);

    // rounding
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("round valid", out_valid, 1);
`ifdef ROUND_EN
    chk("round d0", out_data[0], 1);
`else
    chk("round d0", out_data[0], 0);
`endif
    idle();

    // full scale
    repeat (4) step(1, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF);
    chk("full d0", out_data[0], 'hFFFF);
    chk("full d3", out_data[3], 'hFFFF);
    idle();

    // continuous stream
    for (int i = 0; i < 12; i++) begin
      step(1, i, 3 * i, 100 + i, 7);
      if (out_valid) begin
        p_idx.push_back(i);
        p_val.push_back(int'(out_data[0]));
      end
    end
    idle();
    chk("stream pulses", p_idx.size(), 3);
    if (p_idx.size() == 3) begin
      chk("stream t0", p_idx[0], 3);
      chk("stream t1", p_idx[1], 7);
      chk("stream t2", p_idx[2], 11);
`ifdef ROUND_EN
      chk("stream v0", p_val[0], 2);
      chk("stream v1", p_val[1], 6);
      chk("stream v2", p_val[2], 10);
`else
      chk("stream v0", p_val[0], 1);
      chk("stream v1", p_val[1], 5);
      chk("stream v2", p_val[2], 9);
`endif
    end

    // clear together with in_valid
    pulses = 0;
    step(1, 8, 8, 8, 8);
    step(1, 8, 8, 8, 8);
    step(1, 8, 8, 8, 8, 1'b1);
    chk("clear busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 4, 4, 4, 4);
      if (out_valid) pulses++;
    end
    chk("clear pulses", pulses, 1);
    chk("clear d0", out_data[0], 4);

    // clear in a DUMP cycle: pulse completes, then idle
    step(0, 0, 0, 0, 0, 1'b1);
    chk("clear dump", out_valid, 0);
    chk("clear keep", out_data[1], 4);

    // reset mid-average
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 7, 7, 7, 7);
      if (out_valid) pulses++;
    end
    step(0, 0, 0, 0, 0, 1'b0, 1'b1);
    chk("rst2 valid", out_valid, 0);
    chk("rst2 data", out_data, 0);
    chk("rst2 busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 20, 20, 20, 20);
      if (out_valid) pulses++;
    end
    chk("rst2 pulses", pulses, 1);
    chk("rst2 d0", out_data[0], 20);
    idle();
    idle();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
